truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Parametrised, self-checking exhaustive stimulus engine for N-input / M-output combinational blocks.
- Walks every input vector 0..2^N_IN-1 with a configurable dwell time and samples the DUT response on the last dwell cycle.
- Compares each response against a supplied expected truth table and reports error count, first failing vector, pass/fail, and a response signature.
- Instantiated next to the combinational circuit under test. Replaces the hand-written one-vector-per-step sweep and adds looping, abort and checking.

Parameters:
N_IN, 3, number of DUT inputs; the sweep covers 2^N_IN vectors
N_OUT, 3, number of DUT outputs
DWELL, 1, clock cycles each vector is held; legal values 1..255
SIG_W, 16, width of the response signature register (MISR); must be >= N_OUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a sweep; sampled in IDLE or DONE only
cont  input  1  continuous mode; sampled together with start
abort  input  1  stop the sweep, return to IDLE next cycle
exp_table  input  N_OUT*2^N_IN  expected outputs; vector v uses bits [v*N_OUT +: N_OUT]
resp  input  N_OUT  DUT outputs, combinational from stim
stim  output  N_IN  DUT input vector
busy  output  1  high in RUN
done  output  1  high in DONE
pass  output  1  valid when done; 1 when err_count==0
err_count  output  N_IN+1  number of mismatching vectors; saturating
first_err_vec  output  N_IN  vector of the first mismatch
first_err_valid  output  1  first_err_vec holds a captured value
pass_count  output  8  completed full passes; saturates at 255
signature  output  SIG_W  MISR over sampled responses

Behaviour:
- Reset (async, takes effect immediately) drives every output and internal register to 0; state becomes IDLE. Reset mid-sweep discards all results.
- States are IDLE, RUN and DONE; the state, dwell counter and vector counter are registered.
- IDLE/DONE with start=1:
  - clears err_count, first_err_*, pass_count, signature and pass;
  - sets stim=0 and dwell_cnt=0;
  - latches cont into mode_cont;
  - enters RUN.
- start in RUN is ignored.
- RUN, each cycle:
  - if dwell_cnt < DWELL-1, increment dwell_cnt; stim holds.
  - if dwell_cnt == DWELL-1 (the sample edge), then:
    - compare resp with exp_table slice[stim];
    - on mismatch, increment err_count, saturating at all ones;
    - if first_err_valid==0, capture first_err_vec=stim and set first_err_valid=1;
    - update signature: sig <= {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? 16'h100B-style taps : 0) ^ zero-extended resp; the tap constant is fixed at x^16+x^12+x^3+x+1 for SIG_W=16;
    - set dwell_cnt=0.
- Vector advance on a sample edge:
  - if stim < 2^N_IN-1: stim <= stim+1.
  - if stim == 2^N_IN-1 and mode_cont=0: go to DONE; stim holds its last value; pass <= (final err_count==0), including the last compare.
  - if stim == 2^N_IN-1 and mode_cont=1: stim wraps to 0 with no gap cycle; increment pass_count, saturating; errors accumulate across passes.
- Single-pass latency: start edge to the first DONE cycle is 2^N_IN*DWELL cycles.
- abort in RUN, from any dwell position:
  - next state is IDLE, busy=0, stim=0;
  - any sample edge in the same cycle is discarded;
  - results remain readable;
  - done stays 0 and pass stays 0.
- abort in IDLE or DONE has no effect. abort and start in the same cycle: abort wins.
- DONE holds all results until start or reset.
- The only combinational outputs are busy and done, each decoded from state.

Test Plan:
- N_IN=3, N_OUT=3, DWELL=1, DUT = exp_table, start pulse -> stim 0,1..7 one cycle each; done at cycle 8 after start; pass=1, err_count=0, first_err_valid=0, busy low in DONE.
- Same setup, DUT output F2 inverted for vector 5 only -> err_count=1, first_err_vec=5, first_err_valid=1, pass=0.
- Faults at vectors 2 and 6 -> err_count=2, first_err_vec=2; signature differs from the fault-free run; a repeated fault-free run gives an identical signature.
- DWELL=3 -> each stim value held exactly 3 cycles; done 24 cycles after start; resp glitches in the first two dwell cycles do not affect err_count.
- cont=1 with start -> stim wraps 7->0 back-to-back; pass_count=3 after 24 cycles; abort at vector 4 -> IDLE next cycle, stim=0, done=0, pass_count stays 3.
- rst pulsed mid-sweep at vector 4 -> all outputs 0 immediately, without waiting for a clock; start during RUN is ignored (vector sequence unchanged).

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector into a combinational
// block, checks each response against an expected table and folds it into a MISR.
module truth_table_sweeper #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 3,
  parameter int DWELL = 1,
  parameter int SIG_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          cont,
  input  logic                          abort,
  input  logic [N_OUT*(2**N_IN)-1:0]    exp_table,
  input  logic [N_OUT-1:0]              resp,
  output logic [N_IN-1:0]               stim,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 err_count,
  output logic [N_IN-1:0]               first_err_vec,
  output logic                          first_err_valid,
  output logic [7:0]                    pass_count,
  output logic [SIG_W-1:0]              signature
);

  localparam logic [SIG_W-1:0] SIG_TAPS   = SIG_W'(16'h100B);
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       dwell_cnt;
  logic             mode_cont;

  logic             start_ok;
  logic             sample_edge;
  logic             last_vec;
  logic [N_OUT-1:0] exp_bits;
  logic             mismatch;
  logic [N_IN:0]    err_next;
  logic [SIG_W-1:0] sig_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // abort outranks both start and a coincident sample edge.
  always_comb begin
    state_next  = state;
    start_ok    = 1'b0;
    sample_edge = 1'b0;
    last_vec    = (stim == {N_IN{1'b1}});
    exp_bits    = exp_table[int'(stim)*N_OUT +: N_OUT];
    mismatch    = (resp != exp_bits);
    err_next    = (mismatch && (err_count != {(N_IN+1){1'b1}})) ? err_count + 1'b1 : err_count;
    sig_next    = {signature[SIG_W-2:0], 1'b0}
                ^ (signature[SIG_W-1] ? SIG_TAPS : {SIG_W{1'b0}})
                ^ SIG_W'(resp);
    case (state)
      S_IDLE, S_DONE: begin
        start_ok = start && !abort;
        if (start_ok) state_next = S_RUN;
      end
      S_RUN: begin
        sample_edge = !abort && (dwell_cnt == DWELL_LAST);
        if (abort)
          state_next = S_IDLE;
        else if (sample_edge && last_vec && !mode_cont)
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim            <= '0;
      dwell_cnt       <= '0;
      mode_cont       <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      pass_count      <= '0;
      signature       <= '0;
    end else if (start_ok) begin
      stim            <= '0;
      dwell_cnt       <= '0;
      mode_cont       <= cont;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      pass_count      <= '0;
      signature       <= '0;
    end else if (state == S_RUN) begin
      if (abort) begin
        stim      <= '0;
        dwell_cnt <= '0;
      end else if (sample_edge) begin
        dwell_cnt <= '0;
        err_count <= err_next;
        signature <= sig_next;
        if (mismatch && !first_err_valid) begin
          first_err_vec   <= stim;
          first_err_valid <= 1'b1;
        end
        // Continuous mode wraps straight back to vector 0 with no idle cycle.
        if (!last_vec) begin
          stim <= stim + 1'b1;
        end else if (mode_cont) begin
          stim <= '0;
          if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
        end else begin
          pass <= (err_next == '0);
        end
      end else begin
        dwell_cnt <= dwell_cnt + 8'd1;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one-cycle and three-cycle dwell instances
// driven against a known 3-in/3-out table with injectable response faults.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] exp_table;
  logic [2:0]  tbl   [0:7];
  logic [2:0]  mask1 [0:7];
  logic        glitch3;

  logic        start1, cont1, abort1;
  logic [2:0]  resp1, stim1;
  logic        busy1, done1, pass1, fe_val1;
  logic [3:0]  err1;
  logic [2:0]  fe_vec1;
  logic [7:0]  pc1;
  logic [15:0] sig1;

  logic        start3, cont3, abort3;
  logic [2:0]  resp3, stim3;
  logic        busy3, done3, pass3, fe_val3;
  logic [3:0]  err3;
  logic [2:0]  fe_vec3;
  logic [7:0]  pc3;
  logic [15:0] sig3;

  int errors = 0;
  int checks = 0;
  logic [15:0] sig_clean, sig_fault, sig_repeat;

  always #5 clk = ~clk;

  assign resp1 = tbl[stim1] ^ mask1[stim1];
  assign resp3 = tbl[stim3] ^ (glitch3 ? 3'b111 : 3'b000);

  truth_table_sweeper #(.N_IN(3), .N_OUT(3), .DWELL(1), .SIG_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .abort(abort1),
    .exp_table(exp_table), .resp(resp1), .stim(stim1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_err_vec(fe_vec1), .first_err_valid(fe_val1),
    .pass_count(pc1), .signature(sig1)
  );

  truth_table_sweeper #(.N_IN(3), .N_OUT(3), .DWELL(3), .SIG_W(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .cont(cont3), .abort(abort3),
    .exp_table(exp_table), .resp(resp3), .stim(stim3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .first_err_vec(fe_vec3), .first_err_valid(fe_val3),
    .pass_count(pc3), .signature(sig3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected MISR over one full pass of dut1 with the current fault mask.
  function automatic logic [15:0] model_sig();
    logic [15:0] s;
    logic [2:0]  r;
    s = 16'h0000;
    for (int v = 0; v < 8; v++) begin
      r = tbl[v] ^ mask1[v];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {13'b0, r};
    end
    return s;
  endfunction

  task automatic sweep1(input string tag);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_stim%0d", tag, k), 32'(stim1), 32'(k));
      tick();
    end
    chk({tag, "_done"}, 32'(done1), 32'd1);
    chk({tag, "_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_sig"},  32'(sig1),  32'(model_sig()));
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; cont1 = 1'b0; abort1 = 1'b0;
    start3 = 1'b0; cont3 = 1'b0; abort3 = 1'b0;
    glitch3 = 1'b0;
    tbl[0] = 3'd6; tbl[1] = 3'd3; tbl[2] = 3'd5; tbl[3] = 3'd0;
    tbl[4] = 3'd7; tbl[5] = 3'd2; tbl[6] = 3'd4; tbl[7] = 3'd1;
    for (int v = 0; v < 8; v++) begin
      exp_table[v*3 +: 3] = tbl[v];
      mask1[v] = 3'b000;
    end
    #3;
    chk("rst_stim", 32'(stim1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_sig",  32'(sig1),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fault-free single pass.
    sweep1("clean");
    chk("clean_pass", 32'(pass1),   32'd1);
    chk("clean_err",  32'(err1),    32'd0);
    chk("clean_fev",  32'(fe_val1), 32'd0);
    sig_clean = sig1;
    tick(); tick();
    chk("done_hold_sig", 32'(sig1), 32'(sig_clean));

    // F2 inverted at vector 5 only.
    mask1[5] = 3'b100;
    sweep1("f5");
    chk("f5_err",  32'(err1),    32'd1);
    chk("f5_fe",   32'(fe_vec1), 32'd5);
    chk("f5_fev",  32'(fe_val1), 32'd1);
    chk("f5_pass", 32'(pass1),   32'd0);
    mask1[5] = 3'b000;

    // Faults at vectors 2 and 6.
    mask1[2] = 3'b001;
    mask1[6] = 3'b010;
    sweep1("f26");
    chk("f26_err", 32'(err1),    32'd2);
    chk("f26_fe",  32'(fe_vec1), 32'd2);
    sig_fault = sig1;
    chk("f26_sig_differs", 32'(sig_fault != sig_clean), 32'd1);
    mask1[2] = 3'b000;
    mask1[6] = 3'b000;

    sweep1("repeat");
    sig_repeat = sig1;
    chk("repeat_sig_same", 32'(sig_repeat == sig_clean), 32'd1);
    chk("repeat_pass", 32'(pass1), 32'd1);

    // Three-cycle dwell with resp glitching outside the sample cycle.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      glitch3 = 1'b1;
      chk($sformatf("d3_stim%0d_a", k), 32'(stim3), 32'(k));
      tick();
      chk($sformatf("d3_stim%0d_b", k), 32'(stim3), 32'(k));
      tick();
      glitch3 = 1'b0;
      chk($sformatf("d3_stim%0d_c", k), 32'(stim3), 32'(k));
      chk($sformatf("d3_done_early%0d", k), 32'(done3), 32'd0);
      tick();
    end
    chk("d3_done", 32'(done3), 32'd1);
    chk("d3_err",  32'(err3),  32'd0);
    chk("d3_pass", 32'(pass3), 32'd1);

    // Continuous mode: three wraps, then abort at vector 4.
    cont1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cont1 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("cont_stim%0d", k), 32'(stim1), 32'(k % 8));
      chk($sformatf("cont_pc%0d", k),   32'(pc1),   32'(k / 8));
      tick();
    end
    chk("cont_pc3",  32'(pc1),   32'd3);
    chk("cont_wrap", 32'(stim1), 32'd0);
    chk("cont_busy", 32'(busy1), 32'd1);
    tick(); tick(); tick(); tick();
    chk("cont_v4", 32'(stim1), 32'd4);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_stim", 32'(stim1), 32'd0);
    chk("abort_pc",   32'(pc1),   32'd3);
    chk("abort_pass", 32'(pass1), 32'd0);

    // Reset mid-sweep, with an ignored start in RUN and a fault to clear.
    mask1[2] = 3'b001;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(); tick();
    chk("run_v2", 32'(stim1), 32'd2);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("run_start_ignored", 32'(stim1), 32'd3);
    chk("run_err_pre", 32'(err1), 32'd1);
    tick();
    chk("run_v4", 32'(stim1), 32'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_stim", 32'(stim1),   32'd0);
    chk("mrst_busy", 32'(busy1),   32'd0);
    chk("mrst_err",  32'(err1),    32'd0);
    chk("mrst_fev",  32'(fe_val1), 32'd0);
    chk("mrst_fe",   32'(fe_vec1), 32'd0);
    chk("mrst_sig",  32'(sig1),    32'd0);
    chk("mrst_pc",   32'(pc1),     32'd0);
    chk("mrst_pass", 32'(pass1),   32'd0);
    rst = 1'b0;
    mask1[2] = 3'b000;
    tick(); tick();
    chk("post_rst_idle", 32'(busy1 | done1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
